// File: rtl/pll_reset_seq.sv
// PLL bring-up and reset sequencer.
// Holds the PLL in reset, waits for lock, debounces it, then releases the
// per-domain resets one by one with a fixed stagger. Any loss of lock after
// release restarts the whole sequence. All outputs come from registers or
// from a decode of the registered state, never directly from an input.
module pll_reset_seq #(
  parameter int NUM_CLOCKS      = 5,
  parameter int PLL_RST_CYCLES  = 16,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int STAGGER_CYCLES  = 64,
  parameter int CNT_W           = 8
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  locked,
  output logic                  pll_rst,
  output logic [NUM_CLOCKS-1:0] chan_rst,
  output logic                  ready,
  output logic [CNT_W-1:0]      relock_cnt,
  output logic [CNT_W-1:0]      retry_cnt,
  output logic [2:0]            state_dbg
);

  // One counter serves every timed state, so size it for the longest wait.
  localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD = (DEBOUNCE_CYCLES > STAGGER_CYCLES * NUM_CLOCKS) ?
                          DEBOUNCE_CYCLES : STAGGER_CYCLES * NUM_CLOCKS;
  localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW = $clog2(MAX_ALL + 1);
  localparam int IW = $clog2(NUM_CLOCKS + 1);

  localparam logic [CW-1:0] PRC_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] LT_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] DC_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0] IDX_END  = IW'(NUM_CLOCKS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_PLL_RESET = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_DEBOUNCE  = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [IW-1:0]         idx, idx_n;
  logic [NUM_CLOCKS-1:0] chan_n;
  logic [CNT_W-1:0]      relock_n, retry_n;
  logic                  sync1, locked_s;

  // Lock is asynchronous to refclk; only locked_s is used downstream.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= locked;
      locked_s <= sync1;
    end
  end

  // State, counter, channel index, channel resets and status counters.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state      <= S_PLL_RESET;
      cnt        <= '0;
      idx        <= '0;
      chan_rst   <= '1;
      relock_cnt <= '0;
      retry_cnt  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      chan_rst   <= chan_n;
      relock_cnt <= relock_n;
      retry_cnt  <= retry_n;
    end
  end

  // Next-state logic; a lock loss after release wins over stagger timing.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    chan_n   = chan_rst;
    relock_n = relock_cnt;
    retry_n  = retry_cnt;
    case (state)
      S_PLL_RESET: begin
        if (cnt == PRC_LAST) begin
          state_n = S_WAIT_LOCK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_n = S_DEBOUNCE;
          cnt_n   = '0;
        end else if (cnt == LT_LAST) begin
          state_n = S_PLL_RESET;
          cnt_n   = '0;
          if (retry_cnt != CNT_MAX) retry_n = retry_cnt + CNT_W'(1);
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DEBOUNCE: begin
        if (!locked_s) begin
          state_n = S_WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == DC_LAST) begin
          state_n   = S_RELEASE;
          cnt_n     = '0;
          chan_n[0] = 1'b0;
          idx_n     = IW'(1);
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_RELEASE, S_RUN: begin
        if (!locked_s) begin
          state_n = S_PLL_RESET;
          cnt_n   = '0;
          idx_n   = '0;
          chan_n  = '1;
          if (relock_cnt != CNT_MAX) relock_n = relock_cnt + CNT_W'(1);
        end else if (state == S_RELEASE) begin
          if (cnt == ST_LAST) begin
            cnt_n = '0;
            if (idx == IDX_END) begin
              state_n = S_RUN;
            end else begin
              for (int k = 0; k < NUM_CLOCKS; k++) begin
                if (idx == IW'(k)) chan_n[k] = 1'b0;
              end
              idx_n = idx + IW'(1);
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_n = S_PLL_RESET;
        cnt_n   = '0;
        idx_n   = '0;
        chan_n  = '1;
      end
    endcase
  end

  assign pll_rst   = (state == S_PLL_RESET);
  assign ready     = (state == S_RUN);
  assign state_dbg = state;

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter NUM_CLOCKS, default 5, meaning number of PLL output clock domains sequenced (legal 1..18).
REQ-002 SHALL have parameter PLL_RST_CYCLES, default 16, meaning the number of cycles pll_rst is held high per reset attempt (legal ≥2).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65536, meaning the number of WAIT_LOCK cycles allowed before a retry (legal ≥2).
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 1024, meaning the number of consecutive locked cycles required (legal ≥1).
REQ-005 SHALL have parameter STAGGER_CYCLES, default 64, meaning the spacing between successive channel reset releases (legal ≥1).
REQ-006 SHALL have parameter CNT_W, default 8, meaning the width of the status counters.
REQ-007 SHALL have port refclk, input, 1 bit: the single clock; the reference clock also fed to the PLL.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port locked, input, 1 bit: PLL lock indicator, asynchronous to refclk.
REQ-010 SHALL have port pll_rst, output, 1 bit: reset to the PLL, active-high.
REQ-011 SHALL have port chan_rst, output, NUM_CLOCKS bits: per-domain reset, active-high; bit k pairs with outclk_k.
REQ-012 SHALL have port ready, output, 1 bit: all domains released and lock stable.
REQ-013 SHALL have port relock_cnt, output, CNT_W bits: count of lock losses after RUN or RELEASE was reached.
REQ-014 SHALL have port retry_cnt, output, CNT_W bits: count of lock timeouts.

Function
REQ-015 SHALL synchronise locked through two refclk flops to locked_s; no other logic SHALL sample locked directly.
REQ-016 SHALL implement the states PLL_RESET, WAIT_LOCK, DEBOUNCE, RELEASE and RUN, with a single cycle counter and a channel index.
REQ-017 SHALL hold PLL_RESET for exactly PLL_RST_CYCLES cycles with pll_rst=1, then enter WAIT_LOCK with the counter cleared.
REQ-018 SHALL assert pll_rst only in PLL_RESET.
REQ-019 SHALL, in WAIT_LOCK, move to DEBOUNCE with the counter cleared when locked_s=1.
REQ-020 SHALL, in WAIT_LOCK, move to PLL_RESET and increment retry_cnt after LOCK_TIMEOUT cycles with locked_s=0.
REQ-021 SHALL, in DEBOUNCE, return to WAIT_LOCK with the counter cleared on any locked_s=0 (no counter increment).
REQ-022 SHALL, in DEBOUNCE, enter RELEASE after DEBOUNCE_CYCLES consecutive cycles with locked_s=1.
REQ-023 SHALL, in RELEASE, deassert chan_rst[0] in the first RELEASE cycle.
REQ-024 SHALL, in RELEASE, deassert chan_rst[k] exactly k*STAGGER_CYCLES cycles after chan_rst[0].
REQ-025 SHALL, in RELEASE, enter RUN STAGGER_CYCLES cycles after the last channel is deasserted.
REQ-026 SHALL assert ready only in RUN.
REQ-027 SHALL, on locked_s=0 in RELEASE or RUN, enter PLL_RESET next cycle, re-assert all chan_rst bits and deassert ready in that same cycle, and increment relock_cnt.
REQ-028 SHALL make a deasserted chan_rst bit change only by returning to 1, and only on a transition to PLL_RESET.
REQ-029 SHALL saturate relock_cnt and retry_cnt at 2^CNT_W-1 (no wrap).
REQ-030 SHALL give rst priority over all events, including a lock transition in the same cycle.
REQ-031 SHALL decode all outputs from registered state only; outputs SHALL have no combinational path from any input.
REQ-032 SHALL use counters wide enough for the largest of PLL_RST_CYCLES, LOCK_TIMEOUT, DEBOUNCE_CYCLES and STAGGER_CYCLES*NUM_CLOCKS.

Reset
REQ-033 SHALL, while rst=1, set: state=PLL_RESET, counter=0, channel index=0, sync flops=0, pll_rst=1, chan_rst=all ones, ready=0, relock_cnt=0, retry_cnt=0.
REQ-034 SHALL make rst asserted mid-sequence (any state) take effect on the next edge, and SHALL restart the full sequence after rst falls.

Verification (NUM_CLOCKS=3, PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, DEBOUNCE_CYCLES=8, STAGGER_CYCLES=4; cycle 0 = first edge with rst=0)
REQ-035 SHALL cover nominal bring-up: locked=1 throughout -> pll_rst=1 on cycles 0-3, DEBOUNCE 5-12, chan_rst[0]=0 at 13, chan_rst[1]=0 at 17, chan_rst[2]=0 at 21, ready=1 at 25.
REQ-036 SHALL cover timeout: locked=0 throughout -> WAIT_LOCK 4-35, pll_rst=1 on 36-39, retry_cnt=1; after 8 timeouts retry_cnt=8.
REQ-037 SHALL cover a debounce glitch: locked low for 1 cycle mid-DEBOUNCE -> return to WAIT_LOCK, full 8-cycle debounce restarts, chan_rst stays 3'b111, relock_cnt=0.
REQ-038 SHALL cover lock loss in RUN: locked falls -> within 3 cycles chan_rst=3'b111, ready=0, pll_rst=1, relock_cnt=1; the sequence then repeats as in REQ-035.
REQ-039 SHALL cover lock loss mid-RELEASE: locked falls after chan_rst[0] is released -> all chan_rst=1, relock_cnt increments, and chan_rst[2] is never released during that sequence.
REQ-040 SHALL cover saturation and reset: 300 forced lock losses with CNT_W=8 -> relock_cnt=255; then rst=1 for 1 cycle -> every output matches REQ-033.
